// File: rtl/comparador_serial_param.sv
// rtl/comparador_serial_param.sv - bit-serial MSB-first magnitude comparator with start/pronto handshake
//
// Purpose: compares two WIDTH-bit operands one bit per clock, starting at the
// MSB and stopping at the first differing bit. Each operation is either
// unsigned or two's-complement signed.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - request a comparison (sampled only while idle)
//   com_sinal  - 1 = signed two's complement, 0 = unsigned
//   a, b       - operands, captured on the accept edge
//   ocupado    - comparison in progress
//   pronto     - one-cycle result-valid pulse
//   maior      - A > B
//   menor      - A < B
//   igual      - A == B

module comparador_serial_param #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             com_sinal,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ocupado,
    output logic             pronto,
    output logic             maior,
    output logic             menor,
    output logic             igual
);

    typedef enum logic {
        OCIOSO  = 1'b0,
        COMPARA = 1'b1
    } estado_t;

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    estado_t          r_estado;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sinal;
    logic [IDX_W-1:0] r_idx;
    logic             r_ocupado;
    logic             r_pronto;
    logic             r_maior;
    logic             r_menor;
    logic             r_igual;

    estado_t          w_estado_prox;
    logic [WIDTH-1:0] w_a_prox;
    logic [WIDTH-1:0] w_b_prox;
    logic             w_sinal_prox;
    logic [IDX_W-1:0] w_idx_prox;
    logic             w_ocupado_prox;
    logic             w_pronto_prox;
    logic             w_maior_prox;
    logic             w_menor_prox;
    logic             w_igual_prox;

    logic             w_bit_a;
    logic             w_bit_b;

    assign w_bit_a = r_a[r_idx];
    assign w_bit_b = r_b[r_idx];

    always_comb begin
        w_estado_prox  = r_estado;
        w_a_prox       = r_a;
        w_b_prox       = r_b;
        w_sinal_prox   = r_sinal;
        w_idx_prox     = r_idx;
        w_ocupado_prox = r_ocupado;
        w_pronto_prox  = 1'b0;
        w_maior_prox   = r_maior;
        w_menor_prox   = r_menor;
        w_igual_prox   = r_igual;

        unique case (r_estado)
            OCIOSO: begin
                if (start) begin
                    w_a_prox       = a;
                    w_b_prox       = b;
                    w_sinal_prox   = com_sinal;
                    w_idx_prox     = IDX_MSB;
                    w_ocupado_prox = 1'b1;
                    w_maior_prox   = 1'b0;
                    w_menor_prox   = 1'b0;
                    w_igual_prox   = 1'b0;
                    w_estado_prox  = COMPARA;
                end
            end
            COMPARA: begin
                if (w_bit_a != w_bit_b) begin
                    // In signed mode the MSB is the sign bit, so a 1 there
                    // means the smaller value; every other bit has normal weight.
                    if (r_sinal && (r_idx == IDX_MSB)) begin
                        w_menor_prox = w_bit_a;
                        w_maior_prox = ~w_bit_a;
                    end else begin
                        w_maior_prox = w_bit_a;
                        w_menor_prox = ~w_bit_a;
                    end
                    w_pronto_prox  = 1'b1;
                    w_ocupado_prox = 1'b0;
                    w_estado_prox  = OCIOSO;
                end else if (r_idx == '0) begin
                    w_igual_prox   = 1'b1;
                    w_pronto_prox  = 1'b1;
                    w_ocupado_prox = 1'b0;
                    w_estado_prox  = OCIOSO;
                end else begin
                    w_idx_prox = r_idx - 1'b1;
                end
            end
            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= OCIOSO;
            r_a       <= '0;
            r_b       <= '0;
            r_sinal   <= 1'b0;
            r_idx     <= '0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_maior   <= 1'b0;
            r_menor   <= 1'b0;
            r_igual   <= 1'b0;
        end else begin
            r_estado  <= w_estado_prox;
            r_a       <= w_a_prox;
            r_b       <= w_b_prox;
            r_sinal   <= w_sinal_prox;
            r_idx     <= w_idx_prox;
            r_ocupado <= w_ocupado_prox;
            r_pronto  <= w_pronto_prox;
            r_maior   <= w_maior_prox;
            r_menor   <= w_menor_prox;
            r_igual   <= w_igual_prox;
        end
    end

    assign ocupado = r_ocupado;
    assign pronto  = r_pronto;
    assign maior   = r_maior;
    assign menor   = r_menor;
    assign igual   = r_igual;

endmodule

// File: tb/tb_comparador_serial_param.sv
// tb/tb_comparador_serial_param.sv - scoreboard bench for comparador_serial_param

module tb_comparador_serial_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         com_sinal;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ocupado;
    logic         pronto;
    logic         maior;
    logic         menor;
    logic         igual;

    typedef struct {
        logic [2:0] flags;  // {maior, menor, igual}
        int         lat;    // compare edges from accept to decision
    } exp_t;

    localparam logic [2:0] F_MAIOR = 3'b100;
    localparam logic [2:0] F_MENOR = 3'b010;
    localparam logic [2:0] F_IGUAL = 3'b001;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pronto = 0;
    int   busy_cnt = 0;
    logic prev_pronto = 1'b0;

    comparador_serial_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .com_sinal (com_sinal),
        .a         (a),
        .b         (b),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .maior     (maior),
        .menor     (menor),
        .igual     (igual)
    );

    always #5 clk = ~clk;

    // Monitor: samples on the falling edge, pops the scoreboard on each pronto.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_vec++;
            if (pronto) begin
                n_err++;
                $display("FAIL pronto_in_reset: pronto=%0b required 0", pronto);
            end
            busy_cnt = 0;
        end else begin
            if (pronto) begin
                n_pronto++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pronto: flags=%b with empty scoreboard", {maior, menor, igual});
                end else begin
                    e = sb.pop_front();
                    if ({maior, menor, igual} !== e.flags || busy_cnt != e.lat || ocupado !== 1'b0) begin
                        n_err++;
                        $display("FAIL result: flags=%b lat=%0d ocupado=%0b required flags=%b lat=%0d ocupado=0",
                                 {maior, menor, igual}, busy_cnt, ocupado, e.flags, e.lat);
                    end
                end
                if (prev_pronto) begin
                    n_err++;
                    $display("FAIL pronto_width: pronto high two cycles in a row, required one");
                end
                busy_cnt = 0;
            end else if (ocupado) begin
                busy_cnt++;
                if ({maior, menor, igual} !== 3'b000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL busy_flags: flags=%b required 000", {maior, menor, igual});
                end
            end
        end
        prev_pronto = pronto;
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ocupado && !pronto) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: ocupado=%0b required 0 within 40 cycles", ocupado);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic s, input logic [2:0] ef, input int el);
        exp_t e;
        wait_idle();
        a = ta;
        b = tb_v;
        com_sinal = s;
        start = 1'b1;
        e.flags = ef;
        e.lat = el;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
    endtask

    initial begin
        exp_t e;
        int   p0;
        rst = 1'b1;
        start = 1'b0;
        com_sinal = 1'b0;
        a = '0;
        b = '0;

        #12;
        n_vec++;
        if ({ocupado, pronto, maior, menor, igual} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_state: outs=%b required 00000", {ocupado, pronto, maior, menor, igual});
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op(8'd10,  8'd10,  1'b0, F_IGUAL, 8);
        run_op(8'd5,   8'd3,   1'b0, F_MAIOR, 6);
        run_op(8'h80,  8'h7F,  1'b0, F_MAIOR, 1);
        run_op(8'h80,  8'h7F,  1'b1, F_MENOR, 1);
        run_op(8'hFF,  8'h01,  1'b1, F_MENOR, 1);
        run_op(8'hFE,  8'hFD,  1'b1, F_MAIOR, 7);
        run_op(8'h00,  8'h01,  1'b0, F_MENOR, 8);
        run_op(8'h7F,  8'h80,  1'b1, F_MAIOR, 1);
        run_op(8'h96,  8'h96,  1'b1, F_IGUAL, 8);

        // Start and operand changes while busy are ignored
        wait_idle();
        a = 8'd2; b = 8'd12; com_sinal = 1'b0; start = 1'b1;
        e.flags = F_MENOR; e.lat = 5;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'd15; b = 8'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation
        wait_idle();
        a = 8'd0; b = 8'd255; com_sinal = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({ocupado, pronto, maior, menor, igual} !== 5'b0) begin
            n_err++;
            $display("FAIL mid_reset: outs=%b required 00000", {ocupado, pronto, maior, menor, igual});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd255, 8'd0, 1'b0, F_MAIOR, 1);

        // Back-to-back with start held high through the pronto cycle
        wait_idle();
        p0 = n_pronto;
        a = 8'd1; b = 8'd1; com_sinal = 1'b0; start = 1'b1;
        e.flags = F_IGUAL; e.lat = 8;
        sb.push_back(e);
        @(posedge clk);
        #1 a = 8'd0; b = 8'd1;
        e.flags = F_MENOR; e.lat = 8;
        sb.push_back(e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pronto) break;
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_pronto - p0 != 2) begin
            n_err++;
            $display("FAIL b2b_pronto_count: saw %0d pulses required 2", n_pronto - p0);
        end

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
